// File: rtl/rgb_pwm_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pwm_pkg
//   Shared types and defaults for the RGB PWM duty-cycle monitor.
//   - channel_e : index of the three colour channels inside channel vectors
//   - state_e   : window-sequencer states (synchroniser flush, measurement)
//   - PWM_PERIOD_DEF / SYNC_STAGES_DEF : default parameter values
// -----------------------------------------------------------------------------
package rgb_pwm_pkg;

    localparam int NUM_CH          = 3;
    localparam int PWM_PERIOD_DEF  = 1200;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

    typedef enum logic {
        S_FLUSH   = 1'b0,
        S_MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/rgb_pwm_monitor_pwm_high_counter.sv
// -----------------------------------------------------------------------------
// pwm_high_counter
//   One colour channel of the monitor: input synchroniser, high-cycle
//   accumulator and the published duty register.
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   pwm          : raw PWM line (asynchronous to clk)
//   clear        : hold the accumulator at zero (synchroniser flush)
//   accumulate   : add the synchronised sample to the accumulator
//   latch        : last sample of the window; publish acc+sample, restart
//   duty         : high-cycle count of the last completed window
//   changed      : combinational; the value latch would publish differs
//                  from the current duty
// -----------------------------------------------------------------------------
module pwm_high_counter
    import rgb_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm,
    input  logic             clear,
    input  logic             accumulate,
    input  logic             latch,
    output logic [CNT_W-1:0] duty,
    output logic             changed
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic [CNT_W-1:0]       acc_q;
    logic [CNT_W-1:0]       acc_sum;

    // Synchroniser chain; sync_q[0] is the metastability-exposed flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pwm;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sample  = sync_q[SYNC_STAGES-1];

    // The accumulator holds at most PWM_PERIOD-1 before the final add, so the
    // sum always fits in CNT_W bits and no saturation is required.
    assign acc_sum = acc_q + CNT_W'(sample);
    assign changed = (acc_sum != duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            duty  <= '0;
        end else if (latch) begin
            // Publish including the window's final sample, then start fresh
            // so the next window begins with no dead cycle.
            duty  <= acc_sum;
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (accumulate) begin
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/rgb_pwm_monitor.sv
// -----------------------------------------------------------------------------
// rgb_pwm_monitor
//   Measures the duty cycle of the three RGB PWM lines as a count of sampled
//   high cycles per fixed window of PWM_PERIOD clocks. Windows run back to
//   back; each completed window produces a one-cycle meas_valid strobe with
//   the new duty values and a flag telling whether any of them changed.
//
// Parameters:
//   PWM_PERIOD  : clocks per measurement window (>= 2), matches the driver
//   SYNC_STAGES : flops per input synchroniser (>= 1)
//   CNT_W       : derived counter width, not to be overridden
//
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   pwm_r/pwm_g/pwm_b   : PWM lines from the LED driver (asynchronous)
//   duty_r/duty_g/duty_b: high-cycle counts of the last window, 0..PWM_PERIOD
//   meas_valid          : duty_* were updated this cycle
//   meas_changed        : with meas_valid, some duty differs from before
//                         (always set on the first window after reset)
//   win_count           : number of completed windows, wraps at 16 bits
// -----------------------------------------------------------------------------
module rgb_pwm_monitor
    import rgb_pwm_pkg::*;
#(
    parameter  int PWM_PERIOD  = PWM_PERIOD_DEF,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int CNT_W       = $clog2(PWM_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_r,
    input  logic             pwm_g,
    input  logic             pwm_b,
    output logic [CNT_W-1:0] duty_r,
    output logic [CNT_W-1:0] duty_g,
    output logic [CNT_W-1:0] duty_b,
    output logic             meas_valid,
    output logic             meas_changed,
    output logic [15:0]      win_count
);

    localparam int               FL_W       = $clog2(SYNC_STAGES + 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(PWM_PERIOD - 1);

    state_e           state_q;
    state_e           state_d;
    logic [FL_W-1:0]  flush_cnt_q;
    logic [FL_W-1:0]  flush_cnt_d;
    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] win_cnt_d;
    logic             clear;
    logic             accumulate;
    logic             win_end;
    logic             first_win_q;

    logic [NUM_CH-1:0] pwm_vec;
    logic [NUM_CH-1:0] changed_vec;
    logic [CNT_W-1:0]  duty_vec [NUM_CH];

    // ------------------------------------------------------------------
    // Window sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        win_cnt_d   = win_cnt_q;
        clear       = 1'b0;
        accumulate  = 1'b0;
        win_end     = 1'b0;

        case (state_q)
            S_FLUSH: begin
                // Let the synchronisers fill with real pin levels before
                // counting, so reset-time zeros never enter a window.
                clear     = 1'b1;
                win_cnt_d = '0;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = S_MEASURE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            S_MEASURE: begin
                accumulate = 1'b1;
                if (win_cnt_q == WIN_LAST) begin
                    win_end   = 1'b1;
                    win_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = S_FLUSH;
                flush_cnt_d = '0;
                win_cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel counters, indexed by channel_e
    // ------------------------------------------------------------------
    assign pwm_vec[CH_R] = pwm_r;
    assign pwm_vec[CH_G] = pwm_g;
    assign pwm_vec[CH_B] = pwm_b;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pwm_high_counter #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .pwm        (pwm_vec[ch]),
            .clear      (clear),
            .accumulate (accumulate),
            .latch      (win_end),
            .duty       (duty_vec[ch]),
            .changed    (changed_vec[ch])
        );
    end

    assign duty_r = duty_vec[CH_R];
    assign duty_g = duty_vec[CH_G];
    assign duty_b = duty_vec[CH_B];

    // ------------------------------------------------------------------
    // Measurement strobe, change flag and window counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid   <= 1'b0;
            meas_changed <= 1'b0;
            win_count    <= '0;
            first_win_q  <= 1'b1;
        end else begin
            meas_valid   <= win_end;
            // Gated by win_end so the flag is never set without the strobe.
            meas_changed <= win_end & ((|changed_vec) | first_win_q);
            if (win_end) begin
                win_count   <= win_count + 16'd1;
                first_win_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_monitor.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_monitor
//   Randomised bench for rgb_pwm_monitor (PWM_PERIOD=10, SYNC_STAGES=2).
//   The reference model records the pin level present at every clock edge
//   after reset release and sums them per window: window k covers the pin
//   levels at edges (k-1)*P+1 .. k*P and is reported after edge S+k*P.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_monitor;

    localparam int P    = 10;
    localparam int S    = 2;
    localparam int CW   = $clog2(P + 1);
    localparam int MAXW = 128;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_r = 1'b0;
    logic          pwm_g = 1'b0;
    logic          pwm_b = 1'b0;
    logic [CW-1:0] duty_r;
    logic [CW-1:0] duty_g;
    logic [CW-1:0] duty_b;
    logic          meas_valid;
    logic          meas_changed;
    logic [15:0]   win_count;

    always #5 clk = ~clk;

    rgb_pwm_monitor #(
        .PWM_PERIOD  (P),
        .SYNC_STAGES (S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .meas_valid   (meas_valid),
        .meas_changed (meas_changed),
        .win_count    (win_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int e;                       // edges since reset release
    int win_sum [MAXW][3];       // sampled high count per window and channel
    int prev    [3];             // duty the DUT should currently present
    int wc_exp;                  // completed windows since release

    // Stimulus configuration: high when ((n+ph) mod P) < d, or random noise
    int cfg_d    [3];
    int cfg_ph   [3];
    bit cfg_noise[3];

    function automatic bit gen(int ch, int n);
        if (cfg_noise[ch]) return 1'($urandom_range(0, 1));
        return ((n + cfg_ph[ch]) % P) < cfg_d[ch];
    endfunction

    task automatic model_reset();
        e      = 0;
        wc_exp = 0;
        for (int w = 0; w < MAXW; w++)
            for (int c = 0; c < 3; c++) win_sum[w][c] = 0;
        for (int c = 0; c < 3; c++) prev[c] = 0;
    endtask

    task automatic check_outputs();
        bit ev = 1'b0;
        bit ec = 1'b0;
        int k;
        if (e >= S + P && (e - S) % P == 0) begin
            k  = (e - S) / P;
            ev = 1'b1;
            ec = (k == 1);
            for (int c = 0; c < 3; c++) begin
                if (k - 1 < MAXW) begin
                    if (win_sum[k-1][c] != prev[c]) ec = 1'b1;
                    prev[c] = win_sum[k-1][c];
                end
            end
            wc_exp = k;
        end
        chk("meas_valid",   32'(meas_valid),   32'(ev));
        chk("meas_changed", 32'(meas_changed), 32'(ec));
        chk("duty_r",       32'(duty_r),       32'(prev[0]));
        chk("duty_g",       32'(duty_g),       32'(prev[1]));
        chk("duty_b",       32'(duty_b),       32'(prev[2]));
        chk("win_count",    32'(win_count),    32'(wc_exp & 16'hFFFF));
    endtask

    // Drive pins for the next edge, record them, then check after the edge.
    task automatic step();
        int n = e + 1;
        int w = (n - 1) / P;
        bit b [3];
        for (int c = 0; c < 3; c++) begin
            b[c] = gen(c, n);
            if (w < MAXW) win_sum[w][c] += int'(b[c]);
        end
        pwm_r = b[0];
        pwm_g = b[1];
        pwm_b = b[2];
        @(posedge clk);
        e++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) step();
    endtask

    // Asynchronous reset applied at a falling edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_duty_r",     32'(duty_r),       32'd0);
        chk("rst_duty_g",     32'(duty_g),       32'd0);
        chk("rst_duty_b",     32'(duty_b),       32'd0);
        chk("rst_valid",      32'(meas_valid),   32'd0);
        chk("rst_changed",    32'(meas_changed), 32'd0);
        chk("rst_win_count",  32'(win_count),    32'd0);
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input int c, input int d, input int ph, input bit noise);
        cfg_d[c]     = d;
        cfg_ph[c]    = ph;
        cfg_noise[c] = noise;
    endtask

    initial begin
        for (int c = 0; c < 3; c++) set_cfg(c, 0, 0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // All channels low: strobes after edges 12 and 22
        run(25);

        // Red constantly high
        set_cfg(0, P, 0, 1'b0);
        run(40);

        // Green 3 high / 7 low, aligned and then shifted by 5
        set_cfg(0, 0, 0, 1'b0);
        set_cfg(1, 3, 0, 1'b0);
        run(40);
        set_cfg(1, 3, 5, 1'b0);
        run(40);

        // Blue 20% switched to 70% part-way through a window
        set_cfg(1, 0, 0, 1'b0);
        set_cfg(2, 2, 3, 1'b0);
        run(33);
        set_cfg(2, 7, 3, 1'b0);
        run(42);

        // Reset at window position 6 with red high
        set_cfg(0, P, 0, 1'b0);
        set_cfg(2, 0, 0, 1'b0);
        for (int i = 0; i < 2 * P && !(e >= S && (e - S) % P == 6); i++) step();
        chk("abort_align", 32'((e - S) % P), 32'd6);
        do_reset();
        run(30);

        // Random duty, phase and noise, with one reset at a random point
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 3; c++)
                set_cfg(c, $urandom_range(0, P), $urandom_range(0, P - 1),
                        ($urandom_range(0, 3) == 0));
            run($urandom_range(30, 80));
            if (r == 3) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
